// File: rtl/invmat_out_serializer.sv
// Ping-pong buffered row-major streamer for invmat 5x5 results with valid/ready backpressure.
// Build option: define INVMAT_SER_DROP_ERR_EN to discard error matrices at capture (m_err then tied 0).
module invmat_out_serializer #(
    parameter int MAT_SIZE    = 5,
    parameter int IMAT_DWIDTH = 36,
    parameter int CNT_WIDTH   = 16,
    localparam int IDX_W      = (MAT_SIZE > 1) ? $clog2(MAT_SIZE) : 1
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     in_vld,
    input  logic                                     in_err,
    input  logic [IMAT_DWIDTH*MAT_SIZE*MAT_SIZE-1:0] in_mat,
    output logic                                     m_valid,
    input  logic                                     m_ready,
    output logic [IMAT_DWIDTH-1:0]                   m_data,
    output logic [IDX_W-1:0]                         m_row,
    output logic [IDX_W-1:0]                         m_col,
    output logic                                     m_last,
    output logic                                     m_err,
    output logic                                     ovf,
    input  logic                                     ovf_clr,
    output logic [CNT_WIDTH-1:0]                     mat_cnt,
    output logic [1:0]                               occupancy
);

    localparam int NE   = MAT_SIZE * MAT_SIZE;
    localparam int EW   = (NE > 1) ? $clog2(NE) : 1;

    typedef logic [NE-1:0][IMAT_DWIDTH-1:0] mat_t;

    mat_t                 r_buf [2];
    logic                 r_wr_ptr;
    logic                 r_rd_ptr;
    logic [1:0]           r_occ;
    logic [IDX_W-1:0]     r_row;
    logic [IDX_W-1:0]     r_col;
    logic                 r_ovf;
    logic [CNT_WIDTH-1:0] r_mat_cnt;

    logic                 w_valid;
    logic                 w_last;
    logic                 w_xfer;
    logic                 w_last_xfer;
    logic                 w_drop_err;
    logic                 w_cap_req;
    logic                 w_cap;
    logic                 w_ovf_evt;
    logic                 w_col_wrap;
    logic [EW-1:0]        w_elem_idx;

    assign w_valid     = (r_occ != 2'd0);
    assign w_col_wrap  = (r_col == IDX_W'(MAT_SIZE - 1));
    assign w_last      = w_col_wrap && (r_row == IDX_W'(MAT_SIZE - 1));
    assign w_xfer      = w_valid && m_ready;
    assign w_last_xfer = w_xfer && w_last;

`ifdef INVMAT_SER_DROP_ERR_EN
    assign w_drop_err  = in_err;
`else
    assign w_drop_err  = 1'b0;
`endif

    assign w_cap_req   = in_vld && !w_drop_err;
    // A full buffer still accepts a matrix when its read slot frees on this very edge.
    assign w_cap       = w_cap_req && ((r_occ != 2'd2) || w_last_xfer);
    assign w_ovf_evt   = w_cap_req && (r_occ == 2'd2) && !w_last_xfer;

    assign w_elem_idx  = EW'(r_row) * EW'(MAT_SIZE) + EW'(r_col);

    always_ff @(posedge clk) begin
        if (w_cap) begin
            r_buf[r_wr_ptr] <= in_mat;
        end
    end

`ifdef INVMAT_SER_DROP_ERR_EN
    assign m_err = 1'b0;
`else
    logic r_err_buf [2];

    always_ff @(posedge clk) begin
        if (w_cap) begin
            r_err_buf[r_wr_ptr] <= in_err;
        end
    end

    assign m_err = w_valid && r_err_buf[r_rd_ptr];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_occ     <= 2'd0;
            r_row     <= '0;
            r_col     <= '0;
            r_ovf     <= 1'b0;
            r_mat_cnt <= '0;
        end else begin
            if (w_cap) begin
                r_wr_ptr <= !r_wr_ptr;
            end

            case ({w_cap, w_last_xfer})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase

            if (w_last_xfer) begin
                r_row     <= '0;
                r_col     <= '0;
                r_rd_ptr  <= !r_rd_ptr;
                r_mat_cnt <= r_mat_cnt + 1'b1;
            end else if (w_xfer) begin
                if (w_col_wrap) begin
                    r_col <= '0;
                    r_row <= r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end

            if (w_ovf_evt) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign m_valid   = w_valid;
    assign m_data    = r_buf[r_rd_ptr][w_elem_idx];
    assign m_row     = r_row;
    assign m_col     = r_col;
    assign m_last    = w_valid && w_last;
    assign ovf       = r_ovf;
    assign mat_cnt   = r_mat_cnt;
    assign occupancy = r_occ;

endmodule

// File: tb/tb_invmat_out_serializer.sv
// Directed bench for invmat_out_serializer: table of single-matrix streams plus overflow,
// freed-slot, no-bubble and mid-stream reset sequences. Honours INVMAT_SER_DROP_ERR_EN.
module tb_invmat_out_serializer;

    localparam int MS = 5;
    localparam int DW = 36;
    localparam int CW = 16;
    localparam int NE = MS * MS;
    localparam int IW = $clog2(MS);

    logic              clk = 1'b0;
    logic              reset;
    logic              in_vld;
    logic              in_err;
    logic [DW*NE-1:0]  in_mat;
    logic              m_valid;
    logic              m_ready;
    logic [DW-1:0]     m_data;
    logic [IW-1:0]     m_row;
    logic [IW-1:0]     m_col;
    logic              m_last;
    logic              m_err;
    logic              ovf;
    logic              ovf_clr;
    logic [CW-1:0]     mat_cnt;
    logic [1:0]        occupancy;

    int n_chk  = 0;
    int n_fail = 0;
    int exp_cnt = 0;

    invmat_out_serializer #(
        .MAT_SIZE    (MS),
        .IMAT_DWIDTH (DW),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_vld    (in_vld),
        .in_err    (in_err),
        .in_mat    (in_mat),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_row     (m_row),
        .m_col     (m_col),
        .m_last    (m_last),
        .m_err     (m_err),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr),
        .mat_cnt   (mat_cnt),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        bit err;
        int rmode;
        bit exp_err;
        int exp_beats;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] elem(input int kind, input int e);
        case (kind)
            0:       return DW'(e);
            1:       return -DW'(e + 1);
            2:       return 36'h5_0000_0000 + DW'(e * 3);
            default: return 36'hA_5A5A_0000 + DW'(e);
        endcase
    endfunction

    function automatic logic [DW*NE-1:0] mk(input int kind);
        logic [DW*NE-1:0] m;
        m = '0;
        for (int e = 0; e < NE; e++) m[DW*e +: DW] = elem(kind, e);
        return m;
    endfunction

    function automatic logic rdy(input int rmode, input int c);
        case (rmode)
            0:       return 1'b1;
            1:       return (c % 3) == 0;
            default: return (c % 2) == 0;
        endcase
    endfunction

    task automatic cap(input int kind, input bit err);
        in_vld = 1'b1;
        in_err = err;
        in_mat = mk(kind);
        @(negedge clk);
        in_vld = 1'b0;
        in_err = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the final counted beat transferred.
    task automatic stream_check(input int kind, input bit xerr, input int rmode,
                                input int nbeats, input int inj, input bit chk_lat);
        int beat = 0;
        int cyc  = 0;
        while (beat < nbeats && cyc < 300) begin
            in_vld  = 1'b0;
            m_ready = rdy(rmode, cyc);
            if (cyc == 0 && chk_lat) chk($sformatf("latency_valid k%0d", kind), 64'(m_valid), 64'd1);
            if (m_valid) begin
                chk($sformatf("data k%0d b%0d", kind, beat), 64'(m_data), 64'(elem(kind, beat)));
                chk($sformatf("row k%0d b%0d", kind, beat), 64'(m_row), 64'(beat / MS));
                chk($sformatf("col k%0d b%0d", kind, beat), 64'(m_col), 64'(beat % MS));
                chk($sformatf("last k%0d b%0d", kind, beat), 64'(m_last), 64'(beat == NE - 1));
                chk($sformatf("err k%0d b%0d", kind, beat), 64'(m_err), 64'(xerr));
                if (m_ready) begin
                    if (beat == NE - 1 && inj >= 0) begin
                        in_vld = 1'b1;
                        in_err = 1'b0;
                        in_mat = mk(inj);
                    end
                    beat++;
                end
            end
            cyc++;
            @(negedge clk);
        end
        in_vld = 1'b0;
        chk($sformatf("stream_beats k%0d", kind), 64'(beat), 64'(nbeats));
    endtask

    initial begin
        vecs[0] = '{kind: 0, err: 1'b0, rmode: 0, exp_err: 1'b0, exp_beats: NE};
        vecs[1] = '{kind: 1, err: 1'b0, rmode: 1, exp_err: 1'b0, exp_beats: NE};
`ifdef INVMAT_SER_DROP_ERR_EN
        vecs[2] = '{kind: 2, err: 1'b1, rmode: 0, exp_err: 1'b0, exp_beats: 0};
`else
        vecs[2] = '{kind: 2, err: 1'b1, rmode: 0, exp_err: 1'b1, exp_beats: NE};
`endif
        vecs[3] = '{kind: 3, err: 1'b0, rmode: 2, exp_err: 1'b0, exp_beats: NE};

        reset   = 1'b1;
        in_vld  = 1'b0;
        in_err  = 1'b0;
        in_mat  = '0;
        m_ready = 1'b0;
        ovf_clr = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 64'(m_valid), 64'd0);
        chk("rst_row",   64'(m_row),   64'd0);
        chk("rst_col",   64'(m_col),   64'd0);
        chk("rst_last",  64'(m_last),  64'd0);
        chk("rst_err",   64'(m_err),   64'd0);
        chk("rst_ovf",   64'(ovf),     64'd0);
        chk("rst_cnt",   64'(mat_cnt), 64'd0);
        chk("rst_occ",   64'(occupancy), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            cap(vecs[i].kind, vecs[i].err);
            if (vecs[i].exp_beats > 0) begin
                stream_check(vecs[i].kind, vecs[i].exp_err, vecs[i].rmode, vecs[i].exp_beats, -1, 1'b1);
                exp_cnt++;
            end else begin
                repeat (3) begin
                    chk($sformatf("dropped_valid v%0d", i), 64'(m_valid), 64'd0);
                    @(negedge clk);
                end
            end
            chk($sformatf("vec_cnt v%0d", i), 64'(mat_cnt), 64'(exp_cnt));
            chk($sformatf("vec_occ v%0d", i), 64'(occupancy), 64'd0);
            chk($sformatf("vec_ovf v%0d", i), 64'(ovf), 64'd0);
        end

        // overflow: three back-to-back pulses against a stalled consumer
        m_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_vld = 1'b1;
            in_err = 1'b0;
            in_mat = mk(k);
            @(negedge clk);
        end
        in_vld = 1'b0;
        chk("ovf_occ",  64'(occupancy), 64'd2);
        chk("ovf_set",  64'(ovf),       64'd1);
        chk("ovf_head", 64'(m_data),    64'(elem(0, 0)));
        in_vld  = 1'b1;
        in_mat  = mk(3);
        ovf_clr = 1'b1;
        @(negedge clk);
        in_vld  = 1'b0;
        ovf_clr = 1'b0;
        chk("ovf_set_wins", 64'(ovf),       64'd1);
        chk("ovf_occ2",     64'(occupancy), 64'd2);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("ovf_clr", 64'(ovf), 64'd0);
        stream_check(0, 1'b0, 0, NE, -1, 1'b1);
        stream_check(1, 1'b0, 0, NE, -1, 1'b1);
        exp_cnt += 2;
        repeat (3) begin
            chk("ovf_no_third", 64'(m_valid), 64'd0);
            @(negedge clk);
        end
        chk("ovf_cnt", 64'(mat_cnt), 64'(exp_cnt));

        // full buffer, new matrix lands in the slot freed by the last beat
        m_ready = 1'b0;
        cap(0, 1'b0);
        cap(1, 1'b0);
        chk("full_occ", 64'(occupancy), 64'd2);
        stream_check(0, 1'b0, 0, NE, 3, 1'b1);
        chk("freed_ovf", 64'(ovf),       64'd0);
        chk("freed_occ", 64'(occupancy), 64'd2);
        stream_check(1, 1'b0, 0, NE, -1, 1'b1);
        stream_check(3, 1'b0, 0, NE, -1, 1'b1);
        exp_cnt += 3;
        chk("freed_cnt",     64'(mat_cnt),   64'(exp_cnt));
        chk("freed_occ_end", 64'(occupancy), 64'd0);

        // occupancy 1: capture on the last beat, next matrix follows without a bubble
        cap(2, 1'b0);
        stream_check(2, 1'b0, 0, NE, 1, 1'b1);
        chk("nobub_occ", 64'(occupancy), 64'd1);
        stream_check(1, 1'b0, 2, NE, -1, 1'b1);
        exp_cnt += 2;
        chk("nobub_cnt", 64'(mat_cnt), 64'(exp_cnt));

        // reset after ten beats of a matrix
        cap(2, 1'b0);
        stream_check(2, 1'b0, 0, 10, -1, 1'b1);
        m_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("midrst_valid", 64'(m_valid),   64'd0);
        chk("midrst_occ",   64'(occupancy), 64'd0);
        chk("midrst_cnt",   64'(mat_cnt),   64'd0);
        chk("midrst_col",   64'(m_col),     64'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_cnt = 0;
        @(negedge clk);
        cap(0, 1'b0);
        stream_check(0, 1'b0, 0, NE, -1, 1'b1);
        exp_cnt++;
        chk("postrst_cnt", 64'(mat_cnt),   64'(exp_cnt));
        chk("postrst_occ", 64'(occupancy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
